// File: rtl/req_ack_pkg.sv
// ============================================================================
// req_ack_pkg : types shared by the req/ack producer and consumer stages
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package req_ack_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACK_HI = 1'b1
  } rx_state_t;

  // Occupancy counter width for a FIFO of the given depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with occupancy count, registered storage
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [DW-1:0]              data_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/req_ack_rx_fifo.sv
// ============================================================================
// req_ack_rx_fifo : 4-phase req/ack receiver buffering words into a FIFO
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_ack_rx_fifo
  import req_ack_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       req_i,
  input  logic [DW-1:0]              data_i,
  output logic                       ack_o,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  input  logic                       out_ready,
  output logic [cnt_width(DEPTH)-1:0] count
);

  rx_state_t state_q, state_d;
  logic      ack_q, ack_d;
  logic      push;
  logic      full;
  logic      empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // Full is judged on the current count, so a same-cycle pop never frees room.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i && !full) state_d = ACK_HI;
      ACK_HI:  if (!req_i)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push  = (state_q == IDLE) && req_i && !full;
    ack_d = (state_d == ACK_HI);
  end

  assign ack_o     = ack_q;
  assign out_valid = !empty;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  (data_i),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule

`default_nettype wire

// File: tb/tb_req_ack_rx_fifo.sv
// ============================================================================
// tb_req_ack_rx_fifo : vector table, corner sequences and random model check
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_req_ack_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_i;
  logic [DW-1:0] data_i;
  logic          ack_o;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [2:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          req;
    logic [DW-1:0] data;
    logic          rdy;
    logic          ack;
    logic [2:0]    cnt;
    logic          vld;
    logic [DW-1:0] dat;
  } vec_t;

  vec_t vecs[$];

  // Reference model: queue contents plus the acknowledge level.
  logic [DW-1:0] m_q[$];
  logic          m_ack;

  req_ack_rx_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     (req_i),
    .data_i    (data_i),
    .ack_o     (ack_o),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [DW-1:0] d, input logic rd,
                     input logic a, input logic [2:0] c, input logic v,
                     input logic [DW-1:0] dt);
    vec_t e;
    e.req = r; e.data = d; e.rdy = rd; e.ack = a; e.cnt = c; e.vld = v; e.dat = dt;
    vecs.push_back(e);
  endtask

  // Drive at a negedge, let one posedge pass, return at the next negedge.
  task automatic step(input logic r, input logic [DW-1:0] d, input logic rd);
    req_i = r; data_i = d; out_ready = rd;
    @(negedge clk);
  endtask

  task automatic model_edge();
    bit full, pop, push;
    full = (m_q.size() == DEPTH);
    pop  = (m_q.size() != 0) && out_ready;
    push = !m_ack && req_i && !full;
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(data_i);
    m_ack = req_i && (m_ack || push);
  endtask

  initial begin
    rstn = 1'b0; req_i = 1'b0; data_i = '0; out_ready = 1'b0;
    #1 rstn = 1'b1;
    #1;
    check("reset_ack",   ack_o,     0);
    check("reset_valid", out_valid, 0);
    check("reset_count", count,     0);
    check("reset_data",  out_data,  0);
    @(negedge clk);

    // Single handshake, then empty the FIFO.
    add(1, 8'hA5, 0, 1, 1, 1, 8'hA5);
    add(1, 8'hA5, 0, 1, 1, 1, 8'hA5);
    add(0, 8'h00, 0, 0, 1, 1, 8'hA5);
    add(0, 8'h00, 1, 0, 0, 0, 8'h00);
    // Four words fill the FIFO.
    add(1, 8'h01, 0, 1, 1, 1, 8'h01);  add(0, 8'h00, 0, 0, 1, 1, 8'h01);
    add(1, 8'h02, 0, 1, 2, 1, 8'h01);  add(0, 8'h00, 0, 0, 2, 1, 8'h01);
    add(1, 8'h03, 0, 1, 3, 1, 8'h01);  add(0, 8'h00, 0, 0, 3, 1, 8'h01);
    add(1, 8'h04, 0, 1, 4, 1, 8'h01);  add(0, 8'h00, 0, 0, 4, 1, 8'h01);
    // Fifth word is held off; a pop in the same edge does not admit it.
    add(1, 8'h05, 0, 0, 4, 1, 8'h01);
    add(1, 8'h05, 1, 0, 3, 1, 8'h02);
    add(1, 8'h05, 0, 1, 4, 1, 8'h02);
    add(0, 8'h00, 0, 0, 4, 1, 8'h02);
    // Drain in order.
    add(0, 8'h00, 1, 0, 3, 1, 8'h03);
    add(0, 8'h00, 1, 0, 2, 1, 8'h04);
    add(0, 8'h00, 1, 0, 1, 1, 8'h05);
    add(0, 8'h00, 1, 0, 0, 0, 8'h00);
    // Simultaneous push and pop at count 2.
    add(1, 8'h11, 0, 1, 1, 1, 8'h11);  add(0, 8'h00, 0, 0, 1, 1, 8'h11);
    add(1, 8'h22, 0, 1, 2, 1, 8'h11);  add(0, 8'h00, 0, 0, 2, 1, 8'h11);
    add(1, 8'h33, 1, 1, 2, 1, 8'h22);
    add(0, 8'h00, 0, 0, 2, 1, 8'h22);
    add(0, 8'h00, 1, 0, 1, 1, 8'h33);
    add(0, 8'h00, 1, 0, 0, 0, 8'h00);
    // Ready while empty is ignored; push into an empty FIFO still lands.
    add(0, 8'h00, 1, 0, 0, 0, 8'h00);
    add(1, 8'h44, 1, 1, 1, 1, 8'h44);
    add(0, 8'h00, 0, 0, 1, 1, 8'h44);
    add(0, 8'h00, 1, 0, 0, 0, 8'h00);

    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].data, vecs[i].rdy);
      check($sformatf("vec%0d_ack", i), ack_o, vecs[i].ack);
      check($sformatf("vec%0d_cnt", i), count, vecs[i].cnt);
      check($sformatf("vec%0d_vld", i), out_valid, vecs[i].vld);
      if (vecs[i].vld) check($sformatf("vec%0d_dat", i), out_data, vecs[i].dat);
    end

    // Reset in the middle of a handshake with three words buffered.
    step(1, 8'h61, 0);  step(0, 8'h00, 0);
    step(1, 8'h62, 0);  step(0, 8'h00, 0);
    step(1, 8'h63, 0);
    check("prerst_ack", ack_o, 1);
    check("prerst_cnt", count, 3);
    #2 rstn = 1'b0;
    #1;
    check("midrst_ack",  ack_o,     0);
    check("midrst_cnt",  count,     0);
    check("midrst_vld",  out_valid, 0);
    check("midrst_data", out_data,  0);
    req_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step(0, 8'h00, 1);
    check("postrst_ack", ack_o, 0);
    check("postrst_cnt", count, 0);

    // Random producer obeying the handshake against the queue model.
    m_q.delete();
    m_ack = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!req_i) begin
        if ($urandom_range(2) == 0) begin
          req_i  = 1'b1;
          data_i = DW'($urandom);
        end
      end else if (m_ack) begin
        req_i = 1'b0;
      end
      out_ready = (i < 300) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("rnd_ack", ack_o, m_ack);
      check("rnd_cnt", count, m_q.size());
      check("rnd_vld", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("rnd_dat", out_data, m_q[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
